// File: rtl/lsu_mem_port_if.sv
// Request/response and data-memory signal bundle for lsu_mem_port.
// slave is the load/store unit side; master is the requester plus memory side.
interface lsu_mem_port_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misalign;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign,
           mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign,
           mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store unit to a word-wide data memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses with resp_misalign.
//
// state  | meaning
// IDLE   | ready for a request
// LOAD   | sample read word, extract and extend lane
// STORE  | full-word write
// RMW_RD | capture old word for sub-word store
// RMW_WR | write merged word
// RESP   | one-cycle completion pulse
module lsu_mem_port #(
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_mem_port_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  function automatic size_t size_of(input logic [2:0] code);
    case (code)
      3'b000, 3'b100: size_of = SZ_B;
      3'b001, 3'b101: size_of = SZ_H;
      default:        size_of = SZ_W;
    endcase
  endfunction

  state_t            state, state_nxt;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, merge_q, rdata_q;
  logic              misalign_q;
  logic              accept, req_misalign, mem_we, is_unsigned;
  size_t             in_sz, lat_sz;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_val, merged, mem_wdata;

  assign accept      = bus.req_valid && (state == IDLE);
  assign in_sz       = size_of(bus.req_op[2:0]);
  assign lat_sz      = size_of(size_q);
  assign is_unsigned = size_q[2];

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_misalign = ((in_sz == SZ_H) && bus.req_addr[0]) ||
                        ((in_sz == SZ_W) && (bus.req_addr[1:0] != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  always_comb begin
    ld_b   = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_h   = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ld_val = bus.mem_rdata;
    case (lat_sz)
      SZ_B:    ld_val = is_unsigned ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      SZ_H:    ld_val = is_unsigned ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (lat_sz == SZ_B)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_wdata = 32'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_misalign)           state_nxt = RESP;
          else if (!bus.req_op[3])    state_nxt = LOAD;
          else if (in_sz == SZ_W)     state_nxt = STORE;
          else                        state_nxt = RMW_RD;
        end
      end
      LOAD:   state_nxt = RESP;
      STORE: begin
        mem_we    = 1'b1;
        mem_wdata = wdata_q;
        state_nxt = RESP;
      end
      RMW_RD: state_nxt = RMW_WR;
      RMW_WR: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q     <= 3'b0;
      addr_q     <= '0;
      wdata_q    <= 32'b0;
      merge_q    <= 32'b0;
      rdata_q    <= 32'b0;
      misalign_q <= 1'b0;
    end else begin
      if (accept) begin
        size_q  <= bus.req_op[2:0];
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == RMW_RD) merge_q <= bus.mem_rdata;
      // Response fields change only on the way into RESP, then hold.
      if (accept && req_misalign) begin
        rdata_q    <= 32'b0;
        misalign_q <= 1'b1;
      end else if (state == LOAD) begin
        rdata_q    <= ld_val;
        misalign_q <= 1'b0;
      end else if (state == STORE || state == RMW_WR) begin
        rdata_q    <= 32'b0;
        misalign_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.resp_valid    = (state == RESP);
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_misalign = misalign_q;
  assign bus.mem_we        = mem_we;
  assign bus.mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata     = mem_wdata;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: a request-level model predicts every response and write,
// and directed loads/stores pin known results.
module tb_lsu_mem_port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_port_if #(.ADDR_W(32)) bus();
  lsu_mem_port #(.ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  logic [31:0] tb_mem [64];
  logic [31:0] ref_mem [64];
  assign bus.mem_rdata = tb_mem[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // request-level model
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          next_free = 0, resp_cyc = -1, we_cyc = -1, pend_idx = 0;
  logic [31:0] exp_r = 0, hold_r = 0, exp_addr = 0, pend_word = 0;
  logic        exp_m = 0, hold_m = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_free = 0; resp_cyc = -1; we_cyc = -1;
      hold_r = 0; hold_m = 0;
    end else begin
      if (we_cyc == cyc) ref_mem[pend_idx] = pend_word;
      if (resp_cyc == cyc) begin hold_r = exp_r; hold_m = exp_m; end
      if (bus.req_valid && cyc >= next_free) begin
        logic [31:0] a, w, v;
        int nbytes, lane, lat;
        logic sgn, mis;
        a = bus.req_addr;
        case (bus.req_op[2:0])
          3'b000: begin nbytes = 1; sgn = 1; end
          3'b100: begin nbytes = 1; sgn = 0; end
          3'b001: begin nbytes = 2; sgn = 1; end
          3'b101: begin nbytes = 2; sgn = 0; end
          default: begin nbytes = 4; sgn = 0; end
        endcase
`ifdef LSU_MISALIGN_CHECK_EN
        mis = (nbytes == 2 && a[0]) || (nbytes == 4 && a[1:0] != 0);
`else
        mis = 0;
`endif
        lane = (nbytes == 4) ? 0 : (nbytes == 2) ? int'(a[1]) * 2 : int'(a[1:0]);
        pend_idx = int'(a[7:2]);
        exp_addr = {a[31:2], 2'b00};
        w = ref_mem[pend_idx];
        we_cyc = -1;
        exp_m = mis;
        exp_r = 0;
        if (mis) lat = 1;
        else if (bus.req_op[3]) begin
          for (int k = 0; k < nbytes; k++) w[(lane + k) * 8 +: 8] = bus.req_wdata[k * 8 +: 8];
          pend_word = w;
          lat = (nbytes == 4) ? 2 : 3;
          we_cyc = cyc + lat - 1;
        end else begin
          v = w >> (lane * 8);
          if (nbytes == 1) exp_r = sgn ? {{24{v[7]}}, v[7:0]} : {24'b0, v[7:0]};
          else if (nbytes == 2) exp_r = sgn ? {{16{v[15]}}, v[15:0]} : {16'b0, v[15:0]};
          else exp_r = v;
          lat = 2;
        end
        resp_cyc  = cyc + lat;
        next_free = cyc + lat + 1;
      end
    end
  end

  int resp_count = 0, we_count = 0;
  always @(negedge clk) begin
    if (bus.resp_valid) resp_count++;
    if (bus.mem_we) we_count++;
    if (rst_n) begin
      check("req_ready", 32'(bus.req_ready), 32'(cyc >= next_free));
      check("resp_valid", 32'(bus.resp_valid), 32'(cyc == resp_cyc));
      check("mem_we", 32'(bus.mem_we), 32'(cyc == we_cyc));
      if (cyc == we_cyc) begin
        check("mem_addr", bus.mem_addr, exp_addr);
        check("mem_wdata", bus.mem_wdata, pend_word);
      end
      if (cyc == resp_cyc) begin
        check("resp_rdata", bus.resp_rdata, exp_r);
        check("resp_misalign", 32'(bus.resp_misalign), 32'(exp_m));
      end else begin
        check("rdata_hold", bus.resp_rdata, hold_r);
        check("misalign_hold", 32'(bus.resp_misalign), 32'(hold_m));
      end
    end else begin
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] r, output logic m, output int lat);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("ready_timeout", 32'd1, 32'd0);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1; n = 0;
    while (!bus.resp_valid && n < 20) begin @(negedge clk); lat++; n++; end
    if (n >= 20) check("resp_timeout", 32'd1, 32'd0);
    r = bus.resp_rdata;
    m = bus.resp_misalign;
  endtask

  task automatic load_chk(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] exp);
    logic [31:0] r; logic m; int lat;
    send(op, a, 32'h0, r, m, lat);
    check(name, r, exp);
    check({name, "_lat"}, lat, 2);
  endtask

  task automatic store_chk(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] d, input int exp_lat);
    logic [31:0] r; logic m; int lat, we0;
    we0 = we_count;
    send(op, a, d, r, m, lat);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_we_cycles"}, we_count - we0, 1);
    check({name, "_rdata"}, r, 32'h0);
  endtask

  initial begin
    logic [31:0] r; logic m; int lat, t1, we0, rc0;
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] r; logic m; int lat, n, we0, rc0;
    for (int i = 0; i < 64; i++) begin tb_mem[i] = 0; ref_mem[i] = 0; end
    bus.req_valid = 0; bus.req_op = 0; bus.req_addr = 0; bus.req_wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid_lit", 32'(bus.resp_valid), 0);
    check("rst_mem_we_lit", 32'(bus.mem_we), 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_misalign", 32'(bus.resp_misalign), 0);
    check("rst_req_ready", 32'(bus.req_ready), 1);
    #1 rst_n = 1'b1;
    @(negedge clk);

    store_chk("sw10", 4'b1010, 32'h10, 32'hA1B2C3D4, 2);
    check("mem10_after_sw", tb_mem[4], 32'hA1B2C3D4);
    load_chk("lw10", 4'b0010, 32'h10, 32'hA1B2C3D4);
    load_chk("lb13", 4'b0000, 32'h13, 32'hFFFFFFA1);
    load_chk("lbu13", 4'b0100, 32'h13, 32'h000000A1);
    load_chk("lh12", 4'b0001, 32'h12, 32'hFFFFA1B2);
    load_chk("lhu10", 4'b0101, 32'h10, 32'h0000C3D4);
    load_chk("lb10", 4'b0000, 32'h10, 32'hFFFFFFD4);
    load_chk("lbu11", 4'b0100, 32'h11, 32'h000000C3);

    store_chk("sb11", 4'b1000, 32'h11, 32'h000000EE, 3);
    load_chk("lw10_after_sb", 4'b0010, 32'h10, 32'hA1B2EED4);
    store_chk("sh12", 4'b1001, 32'h12, 32'hFFFF1234, 3);
    load_chk("lw10_after_sh", 4'b0010, 32'h10, 32'h1234EED4);

    store_chk("sw_undef_size", 4'b1110, 32'h20, 32'hCAFEF00D, 2);
    load_chk("lw_undef_size", 4'b0011, 32'h20, 32'hCAFEF00D);

    // two requests with req_valid held high throughout
    bus.req_valid = 1; bus.req_op = 4'b0010; bus.req_addr = 32'h10; bus.req_wdata = 0;
    @(posedge clk);
    @(negedge clk);
    bus.req_addr = 32'h20;
    n = 0;
    while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    n = 1;
    while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
    check("b2b_resp_spacing", n, 3);
    check("b2b_second_rdata", bus.resp_rdata, 32'hCAFEF00D);
    bus.req_valid = 0;
    @(negedge clk);

    we0 = we_count;
    send(4'b0010, 32'h12, 32'h0, r, m, lat);
`ifdef LSU_MISALIGN_CHECK_EN
    check("lw12_lat", lat, 1);
    check("lw12_misalign", 32'(m), 1);
    check("lw12_rdata", r, 0);
`else
    check("lw12_lat", lat, 2);
    check("lw12_misalign", 32'(m), 0);
    check("lw12_rdata", r, 32'h1234EED4);
`endif
    send(4'b0001, 32'h11, 32'h0, r, m, lat);
`ifdef LSU_MISALIGN_CHECK_EN
    check("lh11_misalign", 32'(m), 1);
    check("lh11_rdata", r, 0);
`else
    check("lh11_misalign", 32'(m), 0);
    check("lh11_rdata", r, 32'hFFFFEED4);
`endif
    send(4'b1010, 32'h21, 32'h11111111, r, m, lat);
`ifdef LSU_MISALIGN_CHECK_EN
    check("sw21_we_cycles", we_count - we0, 0);
    check("mem20_after_sw21", tb_mem[8], 32'hCAFEF00D);
`else
    check("sw21_we_cycles", we_count - we0, 1);
    check("mem20_after_sw21", tb_mem[8], 32'h11111111);
`endif
    @(negedge clk);

    // reset while an SB sits in RMW_RD
    we0 = we_count; rc0 = resp_count;
    bus.req_valid = 1; bus.req_op = 4'b1000; bus.req_addr = 32'h10; bus.req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_mem_we", 32'(bus.mem_we), 0);
    check("midrst_req_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_we_cycles", we_count - we0, 0);
    check("midrst_resp_count", resp_count - rc0, 0);
    check("midrst_mem10", tb_mem[4], 32'h1234EED4);
    check("midrst_ready_after", 32'(bus.req_ready), 1);
    check("midrst_rdata_cleared", bus.resp_rdata, 0);
    load_chk("lw10_after_rst", 4'b0010, 32'h10, 32'h1234EED4);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit that initiates every access to the byte-addressed, word-wide data memory from the MEM stage. Accepts one request at a time via valid/ready and drives the memory's write enable, word address and write data. For loads it samples the memory's combinational read data and returns the extracted byte, halfword or word. Byte and halfword stores are done as read-modify-write, because the memory writes four bytes per enable.

## Interface
Parameters:
- `ADDR_W`, 32: address width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle; a request is accepted when `req_valid & req_ready`.
- `req_op` in 4: bit 3 = store; bits 2:0 = size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data; the low byte or halfword is used for B/H.
- `resp_valid` out 1: one-cycle completion pulse for both loads and stores.
- `resp_rdata` out 32: load result, extended; 0 for stores.
- `resp_misalign` out 1: access was rejected as misaligned (see Configuration).
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: word-aligned address, `{addr[ADDR_W-1:2],2'b00}`.
- `mem_wdata` out 32: little-endian word; byte k goes to `addr+k`.
- `mem_rdata` in 32: combinational read of the word at `mem_addr`.

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE:
  - `req_ready=1`.
  - On accept, latch op/addr/wdata, then:
    - load → LOAD.
    - SW → STORE.
    - SB/SH → RMW_RD.
    - misaligned (when checking is enabled) → RESP.
- LOAD: capture `mem_rdata`, select lane `addr[1:0]` (byte) or `addr[1]` (half), extend → RESP.
  - B/H sign-extend; BU/HU zero-extend.
- STORE: `mem_we=1`, `mem_wdata=wdata` → RESP.
- RMW_RD: capture `mem_rdata` into the merge register → RMW_WR.
- RMW_WR: `mem_we=1`; `mem_wdata` = captured word with the target byte or halfword lane replaced → RESP.
- RESP: `resp_valid=1` → IDLE.
- `mem_addr` comes from the latched address in every non-IDLE state. `mem_we=0` in all states other than STORE and RMW_WR.
- Undefined size codes (011, 110, 111) behave as W for both loads and stores.
- `resp_rdata` and `resp_misalign` hold their value until the next RESP.

## Timing
- Accept in cycle T. `resp_valid` is asserted in:
  - T+2 for loads and SW.
  - T+3 for SB/SH.
  - T+1 for misaligned rejects.
- `mem_we` is high for exactly one cycle per store: T+1 for SW, T+2 for SB/SH. Data is committed at the end of that cycle.
- Only one request is outstanding. `req_ready=0` from T+1 until the state returns to IDLE.
- Back-to-back: a new request is accepted in the cycle after RESP, so throughput is at best one load every 3 cycles.
- No response backpressure: the consumer must take `resp_valid` when it is asserted.
- Reset values:
  - State IDLE, so `req_ready=1` once `rst_n` is high.
  - `resp_valid=0`, `resp_rdata=0`, `resp_misalign=0`, `mem_we=0`.
  - `mem_addr=0`, `mem_wdata=0`.
- Reset asserted mid-operation:
  - The state machine returns to IDLE asynchronously and `mem_we` drops immediately.
  - No response is issued.
  - An RMW already in progress is abandoned. Memory keeps the old word unless RMW_WR had already completed its clock edge.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - H/HU/SH with `addr[0]=1` skip memory, as do W/SW with `addr[1:0]!=0`.
  - These go IDLE→RESP with `resp_misalign=1` and `resp_rdata=0`, and no `mem_we`.
- Undefined:
  - The unused low address bits are ignored: H uses lane `addr[1]`, W uses the aligned word.
  - `resp_misalign` is tied to 0.

## Test plan
- SW `addr=0x10`, `wdata=0xA1B2C3D4`:
  - Expect `mem_we` for one cycle at T+1, `mem_addr=0x10`, `resp_valid` at T+2.
  - Then LW `0x10` returns `0xA1B2C3D4` at T+2.
- Memory word 0x10 = `0xA1B2C3D4`:
  - LB `0x13` → `0xFFFFFFA1`.
  - LBU `0x13` → `0x000000A1`.
  - LH `0x12` → `0xFFFFA1B2`.
  - LHU `0x10` → `0x0000C3D4`.
- SB `0x11` with `wdata=0x000000EE` over `0xA1B2C3D4`:
  - RMW write of `0xA1B2EED4` at T+2.
  - `resp_valid` at T+3.
  - A following LW returns `0xA1B2EED4`.
- `req_valid` held high for two requests:
  - The second is accepted only in the cycle after the first `resp_valid`.
  - `req_ready=0` in between.
- With the macro: LW `0x12` → `resp_valid` at T+1 with `resp_misalign=1`, `resp_rdata=0`, and no `mem_we`.
  - Without the macro, the same request reads word 0x10 with `resp_misalign=0`.
- `rst_n` pulsed low during RMW_RD of an SB:
  - `mem_we` is never asserted, memory is unchanged, and no `resp_valid`.
  - `req_ready=1` after release.
